fp_compare_unit: RTL

FP_COMPARE_UNIT -- requirements
Module: fp_compare_unit

---
 rtl/fp_pkg.sv | 58 +++++
 rtl/fp_compare_core.sv | 80 ++++++++
 rtl/fp_compare_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point compare unit.
//   - fp_op_e       : operation encoding (FEQ/FLT/FLE/FMIN/FMAX, 101..111 reserved)
//   - FMT_S / FMT_D : format select encoding
//   - CANON_NAN_*   : canonical quiet NaNs (single already NaN-boxed)
//   - fp_classify   : unpacks an operand into sign/magnitude/class bits and the
//                     64-bit value min/max would return for it
package fp_pkg;

    typedef enum logic [2:0] {
        OP_FEQ  = 3'b000,
        OP_FLT  = 3'b001,
        OP_FLE  = 3'b010,
        OP_FMIN = 3'b011,
        OP_FMAX = 3'b100
    } fp_op_e;

    localparam logic FMT_S = 1'b0;
    localparam logic FMT_D = 1'b1;

    localparam logic [63:0] CANON_NAN_D = 64'h7FF8000000000000;
    localparam logic [63:0] CANON_NAN_S = 64'hFFFFFFFF7FC00000;
    localparam logic [31:0] QNAN_S_RAW  = 32'h7FC00000;

    typedef struct packed {
        logic        sign;
        logic [62:0] mag;    // exponent+mantissa, zero-extended for single
        logic        zero;
        logic        nan;
        logic        snan;
        logic [63:0] value;  // operand as min/max returns it (single boxed)
    } fp_class_t;

    // box_bad forces a single operand to the canonical quiet NaN.
    function automatic fp_class_t fp_classify(input logic [63:0] x,
                                              input logic        fmt,
                                              input logic        box_bad);
        fp_class_t   c;
        logic [31:0] s;
        s = box_bad ? QNAN_S_RAW : x[31:0];
        if (fmt == FMT_D) begin
            c.sign  = x[63];
            c.mag   = x[62:0];
            c.zero  = (x[62:0] == 63'd0);
            c.nan   = (&x[62:52]) && (|x[51:0]);
            c.snan  = c.nan && !x[51];
            c.value = x;
        end else begin
            c.sign  = s[31];
            c.mag   = {32'd0, s[30:0]};
            c.zero  = (s[30:0] == 31'd0);
            c.nan   = (&s[30:23]) && (|s[22:0]);
            c.snan  = c.nan && !s[22];
            c.value = {32'hFFFFFFFF, s};
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_compare_core.sv
// Combinational compare / classify core.
// Ports:
//   op, fmt              : operation and format
//   operand_a, operand_b : source operands (single in [31:0])
//   result               : 0/1 for compares, selected/canonical value for min/max
//   flag_nv              : invalid-operation flag
// Macro: FP_CMP_NANBOX_EN -- when defined, a single operand that is not
// properly NaN-boxed (bits [63:32] not all ones) reads as the canonical qNaN.
// Operands are laid out as 64-bit registers; Flen is expected to be 64.
module fp_compare_core
    import fp_pkg::*;
#(
    parameter int Flen = 64
) (
    input  logic [2:0]      op,
    input  logic            fmt,
    input  logic [Flen-1:0] operand_a,
    input  logic [Flen-1:0] operand_b,
    output logic [Flen-1:0] result,
    output logic            flag_nv
);

    logic      box_bad_a, box_bad_b;
    fp_class_t ca, cb;
    logic      any_nan, any_snan, both_zero, eq, a_below, lt;

`ifdef FP_CMP_NANBOX_EN
    assign box_bad_a = (fmt == FMT_S) && (operand_a[63:32] != 32'hFFFFFFFF);
    assign box_bad_b = (fmt == FMT_S) && (operand_b[63:32] != 32'hFFFFFFFF);
`else
    assign box_bad_a = 1'b0;
    assign box_bad_b = 1'b0;
`endif

    assign ca = fp_classify(operand_a[63:0], fmt, box_bad_a);
    assign cb = fp_classify(operand_b[63:0], fmt, box_bad_b);

    assign any_nan   = ca.nan  | cb.nan;
    assign any_snan  = ca.snan | cb.snan;
    assign both_zero = ca.zero & cb.zero;
    assign eq        = both_zero || ((ca.sign == cb.sign) && (ca.mag == cb.mag));

    // Sign-magnitude ordering that treats -0 as below +0 (min/max view).
    assign a_below = (ca.sign != cb.sign) ? ca.sign
                   : (ca.sign ? (ca.mag > cb.mag) : (ca.mag < cb.mag));
    // IEEE ordering: the two zeros compare equal.
    assign lt = !both_zero && a_below;

    always_comb begin
        result  = '0;
        flag_nv = 1'b0;
        case (op)
            OP_FEQ: begin
                result[0] = !any_nan && eq;
                flag_nv   = any_snan;
            end
            OP_FLT: begin
                result[0] = !any_nan && lt;
                flag_nv   = any_nan;
            end
            OP_FLE: begin
                result[0] = !any_nan && (lt || eq);
                flag_nv   = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                flag_nv = any_snan;
                if (ca.nan && cb.nan)
                    result = Flen'((fmt == FMT_D) ? CANON_NAN_D : CANON_NAN_S);
                else if (ca.nan)
                    result = Flen'(cb.value);
                else if (cb.nan)
                    result = Flen'(ca.value);
                else
                    result = Flen'(((op == OP_FMIN) == a_below) ? ca.value : cb.value);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_compare_unit.sv
// Pipelined floating-point compare / min / max unit.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : operation handshake
//   op, fmt, operand_a/b     : operation, format, operands
//   in_tag                   : opaque tag carried to out_tag
//   out_valid/out_ready      : result handshake
//   result, flag_nv, out_tag : presented result
// Macro: FP_CMP_NANBOX_EN (consumed by fp_compare_core).
// The core is evaluated on the input side; Stages registers then carry the
// result. The whole pipeline moves as one, stalling only when the last stage
// holds an untaken result.
module fp_compare_unit
    import fp_pkg::*;
#(
    parameter int Flen     = 64,
    parameter int Stages   = 2,
    parameter int TagWidth = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic                fmt,
    input  logic [Flen-1:0]     operand_a,
    input  logic [Flen-1:0]     operand_b,
    input  logic [TagWidth-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Flen-1:0]     result,
    output logic                flag_nv,
    output logic [TagWidth-1:0] out_tag
);

    typedef struct packed {
        logic [Flen-1:0]     result;
        logic                nv;
        logic [TagWidth-1:0] tag;
    } stage_t;

    logic [Stages:1] vld_pipe;
    stage_t          pipe_q [1:Stages];
    stage_t          stage_in;
    logic [Flen-1:0] core_result;
    logic            core_nv;
    logic            advance;

    fp_compare_core #(.Flen(Flen)) u_core (
        .op        (op),
        .fmt       (fmt),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (core_result),
        .flag_nv   (core_nv)
    );

    assign stage_in = '{result: core_result, nv: core_nv, tag: in_tag};
    assign advance  = !vld_pipe[Stages] || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= Stages; i++) pipe_q[i] <= '0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid;
            pipe_q[1]   <= stage_in;
            for (int i = 2; i <= Stages; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pipe_q[i]   <= pipe_q[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[Stages];
    assign result    = pipe_q[Stages].result;
    assign flag_nv   = pipe_q[Stages].nv;
    assign out_tag   = pipe_q[Stages].tag;

endmodule
